// File: rtl/descrack_pkg.sv
// Shared definitions for the DES crack stream cores: work-vector layout, FSL framing,
// and the transmit-side state encoding.
package descrack_pkg;

    localparam int unsigned VEC_W         = 160;
    localparam int unsigned FSL_W         = 32;
    localparam int unsigned WORDS_PER_VEC = 5;

    localparam int unsigned CT_LSB = 0;
    localparam int unsigned R_LSB  = 64;
    localparam int unsigned T_LSB  = 128;
    localparam int unsigned ID_LSB = 148;

    typedef enum logic [1:0] {
        RESET,
        IDLE,
        SEND
    } state_e;

endpackage

// File: rtl/descrack_credit_ctr.sv
// Credit counter for an FSL link: starts full, take consumes a credit, give returns one.
// Overflow (give while already full, no take) is sticky until rst.
module descrack_credit_ctr #(
    parameter int unsigned MAX = 16,
    localparam int unsigned CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reload_i,
    input  logic          take_i,
    input  logic          give_i,
    output logic [CW-1:0] count_o,
    output logic          nonzero_o,
    output logic          overflow_o
);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (reload_i) begin
            count_d = CW'(MAX);
        end else if (take_i && !give_i) begin
            count_d = count_q - CW'(1);
        end else if (give_i && !take_i) begin
            if (count_q == CW'(MAX)) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CW'(MAX);
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign nonzero_o  = (count_q != '0);
    assign overflow_o = ovf_q;

endmodule

// File: rtl/bus_to_fsl.sv
// Transmit side of a DES crack stream core: pops 160-bit work vectors from a FWFT FIFO and
// serialises them as five 32-bit FSL words, with credit-based flow control and FSL reset.
module bus_to_fsl
    import descrack_pkg::*;
#(
    parameter int unsigned MAX_CREDITS = 16,
    parameter int unsigned RST_CYCLES  = 8,
    localparam int unsigned CW  = $clog2(MAX_CREDITS + 1),
    localparam int unsigned RCW = $clog2(RST_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst_i,
    input  logic [VEC_W-1:0] in_vec,
    input  logic             in_empty,
    output logic             in_rd,
    input  logic             credit_i,
    output logic             fsl_rst_o,
    output logic [FSL_W-1:0] fsl_data_o,
    output logic             fsl_valid_o,
    output logic [CW-1:0]    credits_o,
    output logic             busy_o,
    output logic             cred_err_o,
    output logic [31:0]      vec_count_o
);

    localparam logic [2:0] LastIdx = 3'(WORDS_PER_VEC - 1);

    state_e           state_q, state_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [VEC_W-1:0] sh_q, sh_d;
    logic [FSL_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [31:0]      vcnt_q, vcnt_d;

    logic credit_nz;
    logic last_word;
    logic can_pop;

    assign last_word = (state_q == SEND) && (idx_q == LastIdx);
    assign can_pop   = !in_empty && credit_nz && ((state_q == IDLE) || last_word);

    descrack_credit_ctr #(
        .MAX (MAX_CREDITS)
    ) u_credit_ctr (
        .clk        (clk),
        .rst        (rst),
        .reload_i   (soft_rst_i || (state_q == RESET)),
        .take_i     (in_rd),
        .give_i     (credit_i && (state_q != RESET)),
        .count_o    (credits_o),
        .nonzero_o  (credit_nz),
        .overflow_o (cred_err_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (soft_rst_i) begin
            state_d = RESET;
        end else begin
            unique case (state_q)
                RESET: if (rcnt_q == RCW'(1)) state_d = IDLE;
                IDLE:  if (in_rd) state_d = SEND;
                SEND:  if (last_word && !in_rd) state_d = IDLE;
                default: state_d = RESET;
            endcase
        end
    end

    always_comb begin
        in_rd     = !rst && !soft_rst_i && can_pop;
        fsl_rst_o = (state_q == RESET);
        busy_o    = (state_q != IDLE);
    end

    // Shift register keeps the not-yet-sent words at the bottom; soft reset drops them.
    always_comb begin
        rcnt_d  = rcnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        vcnt_d  = vcnt_q;
        if (soft_rst_i) begin
            rcnt_d = RCW'(RST_CYCLES);
        end else begin
            if ((state_q == RESET) && (rcnt_q != '0)) begin
                rcnt_d = rcnt_q - RCW'(1);
            end
            if (state_q == SEND) begin
                if (idx_q != LastIdx) begin
                    idx_d   = idx_q + 3'd1;
                    data_d  = sh_q[FSL_W-1:0];
                    sh_d    = sh_q >> FSL_W;
                    valid_d = 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 32'd1;
                end
            end
            if (in_rd) begin
                idx_d   = 3'd0;
                data_d  = in_vec[FSL_W-1:0];
                sh_d    = in_vec >> FSL_W;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q  <= RCW'(RST_CYCLES);
            idx_q   <= 3'd0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            vcnt_q  <= 32'd0;
        end else begin
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            vcnt_q  <= vcnt_d;
        end
    end

    assign fsl_data_o  = data_q;
    assign fsl_valid_o = valid_q;
    assign vec_count_o = vcnt_q;

endmodule

// File: tb/tb_bus_to_fsl.sv
// Self-checking bench for bus_to_fsl: a queue-based FIFO feeds random vectors and each
// scenario checks the logged FSL word stream, pops and counters against a simple model.
module tb_bus_to_fsl;
    import descrack_pkg::*;

    localparam int unsigned MAXC = 16;
    localparam int unsigned RSTC = 8;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             soft_rst_i = 1'b0;
    logic [VEC_W-1:0] in_vec     = '0;
    logic             in_empty   = 1'b1;
    logic             in_rd;
    logic             credit_i   = 1'b0;
    logic             fsl_rst_o;
    logic [FSL_W-1:0] fsl_data_o;
    logic             fsl_valid_o;
    logic [CW-1:0]    credits_o;
    logic             busy_o;
    logic             cred_err_o;
    logic [31:0]      vec_count_o;

    always #5 clk = ~clk;

    bus_to_fsl #(
        .MAX_CREDITS (MAXC),
        .RST_CYCLES  (RSTC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst_i  (soft_rst_i),
        .in_vec      (in_vec),
        .in_empty    (in_empty),
        .in_rd       (in_rd),
        .credit_i    (credit_i),
        .fsl_rst_o   (fsl_rst_o),
        .fsl_data_o  (fsl_data_o),
        .fsl_valid_o (fsl_valid_o),
        .credits_o   (credits_o),
        .busy_o      (busy_o),
        .cred_err_o  (cred_err_o),
        .vec_count_o (vec_count_o)
    );

    logic [VEC_W-1:0] fifo[$];
    logic [FSL_W-1:0] wlog[$];
    int               rd_log[$];
    int               vlog[$];
    int               cyc  = 0;
    logic             rd_s = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_credits;
    int   m_vcount;
    logic m_err;

    // Observation log, sampled mid-cycle.
    initial begin : collector
        forever begin
            @(negedge clk);
            cyc++;
            rd_s = in_rd;
            if (in_rd === 1'b1) rd_log.push_back(cyc);
            if (fsl_valid_o === 1'b1) begin
                vlog.push_back(cyc);
                wlog.push_back(fsl_data_o);
            end
        end
    end

    // FWFT FIFO model: a pop seen during a cycle takes effect after that cycle's edge.
    initial begin : fifo_model
        logic pop_now;
        forever begin
            @(posedge clk);
            pop_now = rd_s;
            #2;
            if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
            in_empty = (fifo.size() == 0);
            in_vec   = (fifo.size() > 0) ? fifo[0] : '0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [FSL_W-1:0] word_of(input logic [VEC_W-1:0] v, input int i);
        logic [VEC_W-1:0] s;
        s = v >> (FSL_W * i);
        return s[FSL_W-1:0];
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_logs();
        rd_log.delete();
        vlog.delete();
        wlog.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        credit_i = 1'b0;
        fifo.delete();
        step(3);
        rst = 1'b0;
        step(RSTC + 2);
        m_credits = MAXC;
        m_vcount  = 0;
        m_err     = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (fsl_rst_o !== 1'b1 || fsl_valid_o !== 1'b0 || fsl_data_o !== '0 || in_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rst=%b valid=%b data=%h rd=%b, required 1 0 0 0",
                     fsl_rst_o, fsl_valid_o, fsl_data_o, in_rd);
        end
        n_tests++;
        if (credits_o !== CW'(MAXC) || cred_err_o !== 1'b0 || vec_count_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: credits=%0d err=%b count=%0d, required %0d 0 0",
                     credits_o, cred_err_o, vec_count_o, MAXC);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= int'(RSTC); k++) begin
            @(negedge clk);
            n_tests++;
            if (fsl_rst_o !== 1'b1 || fsl_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: fsl_rst=%b valid=%b, required 1 0",
                         k, fsl_rst_o, fsl_valid_o);
            end
        end
        @(negedge clk);
        n_tests++;
        if (fsl_rst_o !== 1'b0 || busy_o !== 1'b0 || credits_o !== CW'(MAXC)) begin
            n_fail++;
            $display("FAIL reset_release: fsl_rst=%b busy=%b credits=%0d, required 0 0 %0d",
                     fsl_rst_o, busy_o, credits_o, MAXC);
        end
        @(posedge clk);
        #1;
        m_credits = MAXC;
        m_vcount  = 0;
        m_err     = 1'b0;
        clear_logs();
    endtask

    task automatic test_single();
        logic [VEC_W-1:0] v;
        logic [FSL_W-1:0] exp_w[5];
        v = 160'hABC12345_0011223344556677_8899AABBCCDDEEFF;
        exp_w[0] = 32'hCCDDEEFF;
        exp_w[1] = 32'h8899AABB;
        exp_w[2] = 32'h44556677;
        exp_w[3] = 32'h00112233;
        exp_w[4] = 32'hABC12345;
        clear_logs();
        fifo.push_back(v);
        step(14);
        @(negedge clk);
        m_credits -= 1;
        m_vcount  += 1;
        n_tests++;
        if (rd_log.size() != 1 || wlog.size() != 5) begin
            n_fail++;
            $display("FAIL single_counts: pops=%0d words=%0d, required 1 5",
                     rd_log.size(), wlog.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (wlog[i] !== exp_w[i] || vlog[i] != rd_log[0] + 1 + i) begin
                    n_fail++;
                    $display("FAIL single_word%0d: got %h at cycle %0d, required %h at cycle %0d",
                             i, wlog[i], vlog[i], exp_w[i], rd_log[0] + 1 + i);
                end
            end
        end
        n_tests++;
        if (vec_count_o !== 32'(m_vcount) || credits_o !== CW'(m_credits)) begin
            n_fail++;
            $display("FAIL single_counters: count=%0d credits=%0d, required %0d %0d",
                     vec_count_o, credits_o, m_vcount, m_credits);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] vs[3];
        do_reset();
        foreach (vs[i]) begin
            vs[i] = rand_vec();
            fifo.push_back(vs[i]);
        end
        step(25);
        @(negedge clk);
        m_credits -= 3;
        m_vcount  += 3;
        n_tests++;
        if (rd_log.size() != 3 || wlog.size() != 15) begin
            n_fail++;
            $display("FAIL b2b_counts: pops=%0d words=%0d, required 3 15",
                     rd_log.size(), wlog.size());
        end else begin
            n_tests++;
            if (rd_log[1] != rd_log[0] + 5 || rd_log[2] != rd_log[0] + 10) begin
                n_fail++;
                $display("FAIL b2b_pop_spacing: pops at %0d %0d %0d, required spacing 5",
                         rd_log[0], rd_log[1], rd_log[2]);
            end
            for (int i = 0; i < 15; i++) begin
                n_tests++;
                if (wlog[i] !== word_of(vs[i / 5], i % 5) || vlog[i] != rd_log[0] + 1 + i) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d: got %h at cycle %0d, required %h at cycle %0d",
                             i, wlog[i], vlog[i], word_of(vs[i / 5], i % 5), rd_log[0] + 1 + i);
                end
            end
        end
        n_tests++;
        if (credits_o !== CW'(m_credits) || vec_count_o !== 32'(m_vcount)) begin
            n_fail++;
            $display("FAIL b2b_counters: credits=%0d count=%0d, required %0d %0d",
                     credits_o, vec_count_o, m_credits, m_vcount);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_credit_exhaust();
        logic [VEC_W-1:0] vs[MAXC + 2];
        int               nerr;
        do_reset();
        foreach (vs[i]) begin
            vs[i] = rand_vec();
            fifo.push_back(vs[i]);
        end
        step(MAXC * 5 + 10);
        @(negedge clk);
        m_vcount  += m_credits;
        m_credits  = 0;
        n_tests++;
        if (rd_log.size() != MAXC || wlog.size() != MAXC * 5) begin
            n_fail++;
            $display("FAIL exhaust_counts: pops=%0d words=%0d, required %0d %0d",
                     rd_log.size(), wlog.size(), MAXC, MAXC * 5);
        end else begin
            nerr = 0;
            for (int i = 0; i < int'(MAXC * 5); i++) begin
                if (wlog[i] !== word_of(vs[i / 5], i % 5)) nerr++;
            end
            n_tests++;
            if (nerr != 0) begin
                n_fail++;
                $display("FAIL exhaust_words: %0d wrong words, required 0", nerr);
            end
        end
        n_tests++;
        if (credits_o !== CW'(0) || in_rd !== 1'b0 || busy_o !== 1'b0
            || vec_count_o !== 32'(m_vcount)) begin
            n_fail++;
            $display("FAIL exhaust_stall: credits=%0d rd=%b busy=%b count=%0d, required 0 0 0 %0d",
                     credits_o, in_rd, busy_o, vec_count_o, m_vcount);
        end
        @(posedge clk);
        #1;
        clear_logs();
        credit_i = 1'b1;
        step(1);
        credit_i = 1'b0;
        step(12);
        @(negedge clk);
        m_vcount += 1;
        n_tests++;
        if (rd_log.size() != 1 || wlog.size() != 5) begin
            n_fail++;
            $display("FAIL exhaust_resume_counts: pops=%0d words=%0d, required 1 5",
                     rd_log.size(), wlog.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (wlog[i] !== word_of(vs[MAXC], i)) begin
                    n_fail++;
                    $display("FAIL exhaust_resume_word%0d: got %h, required %h",
                             i, wlog[i], word_of(vs[MAXC], i));
                end
            end
        end
        n_tests++;
        if (credits_o !== CW'(m_credits) || vec_count_o !== 32'(m_vcount)) begin
            n_fail++;
            $display("FAIL exhaust_resume_counters: credits=%0d count=%0d, required %0d %0d",
                     credits_o, vec_count_o, m_credits, m_vcount);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pop_credit();
        int exp_rd;
        do_reset();
        exp_rd = cyc + 1;
        fifo.push_back(rand_vec());
        credit_i = 1'b1;
        step(1);
        credit_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rd_log.size() != 1 || rd_log[0] != exp_rd) begin
            n_fail++;
            $display("FAIL popcred_pop: pops=%0d first=%0d, required 1 at cycle %0d",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : -1, exp_rd);
        end
        n_tests++;
        if (credits_o !== CW'(m_credits) || cred_err_o !== m_err) begin
            n_fail++;
            $display("FAIL popcred_same_cycle: credits=%0d err=%b, required %0d %b",
                     credits_o, cred_err_o, m_credits, m_err);
        end
        @(posedge clk);
        #1;
        step(8);
        credit_i = 1'b1;
        step(1);
        credit_i = 1'b0;
        m_err = 1'b1;
        @(negedge clk);
        n_tests++;
        if (credits_o !== CW'(MAXC) || cred_err_o !== m_err) begin
            n_fail++;
            $display("FAIL overflow_set: credits=%0d err=%b, required %0d 1",
                     credits_o, cred_err_o, MAXC);
        end
        @(posedge clk);
        #1;
        fifo.push_back(rand_vec());
        step(12);
        @(negedge clk);
        n_tests++;
        if (cred_err_o !== m_err || credits_o !== CW'(MAXC - 1) || vec_count_o !== 32'd2) begin
            n_fail++;
            $display("FAIL overflow_sticky: err=%b credits=%0d count=%0d, required 1 %0d 2",
                     cred_err_o, credits_o, vec_count_o, MAXC - 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        logic [VEC_W-1:0] va, vb;
        bit               seen;
        do_reset();
        va = rand_vec();
        vb = rand_vec();
        fifo.push_back(va);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (wlog.size() >= 3) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL abort_wait: word 2 not seen within 30 cycles, words=%0d", wlog.size());
            @(posedge clk);
            #1;
            return;
        end
        soft_rst_i = 1'b1;
        step(1);
        soft_rst_i = 1'b0;
        for (int k = 1; k <= int'(RSTC); k++) begin
            @(negedge clk);
            n_tests++;
            if (fsl_rst_o !== 1'b1 || fsl_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_reset cycle %0d: fsl_rst=%b valid=%b, required 1 0",
                         k, fsl_rst_o, fsl_valid_o);
            end
        end
        @(negedge clk);
        n_tests++;
        if (fsl_rst_o !== 1'b0 || credits_o !== CW'(MAXC) || vec_count_o !== 32'(m_vcount)
            || wlog.size() != 3) begin
            n_fail++;
            $display("FAIL abort_after: fsl_rst=%b credits=%0d count=%0d words=%0d, required 0 %0d %0d 3",
                     fsl_rst_o, credits_o, vec_count_o, wlog.size(), MAXC, m_vcount);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (wlog[i] !== word_of(va, i)) begin
                n_fail++;
                $display("FAIL abort_word%0d: got %h, required %h", i, wlog[i], word_of(va, i));
            end
        end
        @(posedge clk);
        #1;
        clear_logs();
        fifo.push_back(vb);
        step(12);
        @(negedge clk);
        m_vcount += 1;
        n_tests++;
        if (wlog.size() != 5) begin
            n_fail++;
            $display("FAIL abort_fresh_count: words=%0d, required 5", wlog.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (wlog[i] !== word_of(vb, i)) begin
                    n_fail++;
                    $display("FAIL abort_fresh_word%0d: got %h, required %h",
                             i, wlog[i], word_of(vb, i));
                end
            end
        end
        n_tests++;
        if (vec_count_o !== 32'(m_vcount) || credits_o !== CW'(MAXC - 1)) begin
            n_fail++;
            $display("FAIL abort_fresh_counters: count=%0d credits=%0d, required %0d %0d",
                     vec_count_o, credits_o, m_vcount, MAXC - 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_exhaust();
        test_pop_credit();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
